// File: rtl/fifo_pair_requester_if.sv
// fifo_pair_requester_if: push/pop, request and tagged-output bundle between
// the upstream writers/arbiter (master) and the FIFO pair (slave).
interface fifo_pair_requester_if #(
   parameter int DATA_WIDTH = 6
);
   logic                  push0, push1;
   logic [DATA_WIDTH-1:0] data_in0, data_in1;
   logic                  pop0, pop1;
   logic                  request0, request1;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  port_out;
   logic                  full0, full1;
   logic                  almost_full0, almost_full1;
   logic                  err;

   modport master (
      output push0, push1, data_in0, data_in1, pop0, pop1,
      input  request0, request1, data_out, valid_out, port_out,
             full0, full1, almost_full0, almost_full1, err
   );

   modport slave (
      input  push0, push1, data_in0, data_in1, pop0, pop1,
      output request0, request1, data_out, valid_out, port_out,
             full0, full1, almost_full0, almost_full1, err
   );
endinterface

// File: rtl/fifo_pair_requester.sv
// fifo_pair_requester: two independent circular FIFOs feeding a two-port
// arbiter. Requests reflect non-empty FIFOs; pops return the head word on a
// registered, port-tagged output. Optional macro ALMOST_FULL_EN builds the
// almost-full comparators; otherwise almost_full0/1 are tied low.

// One FIFO lane: storage, pointers and occupancy.
module fifo_pair_lane #(
   parameter int DATA_WIDTH = 6,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset_L,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DATA_WIDTH-1:0]      data_i,
   output logic [DATA_WIDTH-1:0]      head_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          pop_ok, push_ok;

   // A pop on a non-empty lane frees a slot, so a push to a full lane is
   // still accepted in the same cycle.
   assign pop_ok  = pop_i & (count_q != '0);
   assign push_ok = push_i & ((count_q != DEPTH_C) | pop_ok);
   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next state; pointers wrap naturally (power of two).
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset empties the lane.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (reset_L && push_ok) mem_q[wptr_q] <= data_i;
   end
endmodule

module fifo_pair_requester #(
   parameter int DATA_WIDTH = 6,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = 3
) (
   input  logic                   clk,
   input  logic                   reset_L,
   fifo_pair_requester_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two, at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("AF_THRESH must be in 1..DEPTH");
   end

   logic [1:0]                 push_w, pop_w, empty_w;
   logic [1:0][DATA_WIDTH-1:0] din_w, head_w;
   logic [1:0][AW:0]           count_w;

   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_q, valid_d, port_q, port_d, err_q, err_d;

   // pop1 is dropped whenever pop0 is present; pop0 always wins.
   assign push_w = {bus.push1, bus.push0};
   assign pop_w  = {bus.pop1 & ~bus.pop0, bus.pop0};
   assign din_w  = {bus.data_in1, bus.data_in0};

   for (genvar g = 0; g < 2; g++) begin : g_lane
      fifo_pair_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane (
         .clk     (clk),
         .reset_L (reset_L),
         .push_i  (push_w[g]),
         .pop_i   (pop_w[g]),
         .data_i  (din_w[g]),
         .head_o  (head_w[g]),
         .count_o (count_w[g])
      );
      assign empty_w[g] = (count_w[g] == '0);
   end

   assign bus.request0 = ~empty_w[0];
   assign bus.request1 = ~empty_w[1];
   assign bus.full0    = (count_w[0] == DEPTH_C);
   assign bus.full1    = (count_w[1] == DEPTH_C);
`ifdef ALMOST_FULL_EN
   localparam logic [AW:0] AF_C = AF_THRESH[AW:0];
   assign bus.almost_full0 = (count_w[0] >= AF_C);
   assign bus.almost_full1 = (count_w[1] >= AF_C);
`else
   assign bus.almost_full0 = 1'b0;
   assign bus.almost_full1 = 1'b0;
`endif

   // Output mux and protocol-error detection for the registered response.
   always_comb begin
      data_out_d = data_out_q;
      port_d     = port_q;
      valid_d    = 1'b0;
      if (pop_w[0] && !empty_w[0]) begin
         data_out_d = head_w[0];
         port_d     = 1'b0;
         valid_d    = 1'b1;
      end else if (pop_w[1] && !empty_w[1]) begin
         data_out_d = head_w[1];
         port_d     = 1'b1;
         valid_d    = 1'b1;
      end
      err_d = (bus.push0 & (count_w[0] == DEPTH_C) & ~bus.pop0) |
              (bus.push1 & (count_w[1] == DEPTH_C) & ~bus.pop1) |
              (bus.pop0 & empty_w[0]) |
              (bus.pop1 & (bus.pop0 | empty_w[1]));
   end

   // Registered response.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         data_out_q <= '0;
         valid_q    <= 1'b0;
         port_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         port_q     <= port_d;
         err_q      <= err_d;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.valid_out = valid_q;
   assign bus.port_out  = port_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_fifo_pair_requester.sv
// tb_fifo_pair_requester: cycle-by-cycle vector table with hand-computed
// expectations, plus a back-to-back drain sequence.
module tb_fifo_pair_requester;
   localparam int DW = 6;

   logic clk = 1'b0;
   logic reset_L;
   always #5 clk = ~clk;

   fifo_pair_requester_if #(.DATA_WIDTH(DW)) bus ();

   fifo_pair_requester #(.DATA_WIDTH(DW), .DEPTH(4), .AF_THRESH(3)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   // Bit index 1 = FIFO1, bit index 0 = FIFO0 for the 2-bit fields.
   typedef struct {
      logic          rst_n;
      logic [1:0]    push;
      logic [DW-1:0] d0, d1;
      logic [1:0]    pop;
      logic [1:0]    req;
      logic [DW-1:0] dout;
      logic          vld, port;
      logic [1:0]    full, af;
      logic          err;
   } vec_t;

   vec_t tv[37];
   int total = 0;
   int bad   = 0;

   function automatic logic [1:0] af_exp(input logic [1:0] af);
`ifdef ALMOST_FULL_EN
      return af;
`else
      return 2'b00;
`endif
   endfunction

   task automatic drive(input logic rn, input logic [1:0] push, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input logic [1:0] pop);
      reset_L      = rn;
      bus.push0    = push[0];
      bus.push1    = push[1];
      bus.data_in0 = d0;
      bus.data_in1 = d1;
      bus.pop0     = pop[0];
      bus.pop1     = pop[1];
   endtask

   task automatic check(input string name, input logic [1:0] req, input logic [DW-1:0] dout,
                        input logic vld, input logic port, input logic [1:0] full,
                        input logic [1:0] af, input logic err);
      logic [15:0] act, expv;
      act  = {bus.request1, bus.request0, bus.data_out, bus.valid_out, bus.port_out,
              bus.full1, bus.full0, bus.almost_full1, bus.almost_full0, bus.err};
      expv = {req, dout, vld, port, full, af_exp(af), err};
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got {req,dout,vld,port,full,af,err}=%b_%h_%b%b_%b_%b_%b want %b_%h_%b%b_%b_%b_%b",
                  name, act[15:14], act[13:8], act[7], act[6], act[5:4], act[3:2], act[1],
                  expv[15:14], expv[13:8], expv[7], expv[6], expv[5:4], expv[3:2], expv[1]);
      end
   endtask

   initial begin
      //        rst push d0     d1     pop    req    dout   vld  port full   af     err
      tv[0]  = '{0, 2'b00, 6'h00, 6'h00, 2'b00, 2'b00, 6'h00, 0, 0, 2'b00, 2'b00, 0};
      tv[1]  = '{0, 2'b00, 6'h00, 6'h00, 2'b00, 2'b00, 6'h00, 0, 0, 2'b00, 2'b00, 0};
      tv[2]  = '{1, 2'b00, 6'h00, 6'h00, 2'b00, 2'b00, 6'h00, 0, 0, 2'b00, 2'b00, 0};
      tv[3]  = '{1, 2'b01, 6'h05, 6'h00, 2'b00, 2'b01, 6'h00, 0, 0, 2'b00, 2'b00, 0};
      tv[4]  = '{1, 2'b01, 6'h0A, 6'h00, 2'b00, 2'b01, 6'h00, 0, 0, 2'b00, 2'b00, 0};
      tv[5]  = '{1, 2'b00, 6'h00, 6'h00, 2'b01, 2'b01, 6'h05, 1, 0, 2'b00, 2'b00, 0};
      tv[6]  = '{1, 2'b00, 6'h00, 6'h00, 2'b01, 2'b00, 6'h0A, 1, 0, 2'b00, 2'b00, 0};
      tv[7]  = '{1, 2'b10, 6'h00, 6'h11, 2'b00, 2'b10, 6'h0A, 0, 0, 2'b00, 2'b00, 0};
      tv[8]  = '{1, 2'b10, 6'h00, 6'h12, 2'b00, 2'b10, 6'h0A, 0, 0, 2'b00, 2'b00, 0};
      tv[9]  = '{1, 2'b10, 6'h00, 6'h13, 2'b00, 2'b10, 6'h0A, 0, 0, 2'b00, 2'b10, 0};
      tv[10] = '{1, 2'b10, 6'h00, 6'h14, 2'b00, 2'b10, 6'h0A, 0, 0, 2'b10, 2'b10, 0};
      tv[11] = '{1, 2'b10, 6'h00, 6'h15, 2'b00, 2'b10, 6'h0A, 0, 0, 2'b10, 2'b10, 1};
      tv[12] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 6'h11, 1, 1, 2'b00, 2'b10, 0};
      tv[13] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 6'h12, 1, 1, 2'b00, 2'b00, 0};
      tv[14] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 6'h13, 1, 1, 2'b00, 2'b00, 0};
      tv[15] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b00, 6'h14, 1, 1, 2'b00, 2'b00, 0};
      tv[16] = '{1, 2'b10, 6'h00, 6'h11, 2'b00, 2'b10, 6'h14, 0, 1, 2'b00, 2'b00, 0};
      tv[17] = '{1, 2'b10, 6'h00, 6'h12, 2'b00, 2'b10, 6'h14, 0, 1, 2'b00, 2'b00, 0};
      tv[18] = '{1, 2'b10, 6'h00, 6'h13, 2'b00, 2'b10, 6'h14, 0, 1, 2'b00, 2'b10, 0};
      tv[19] = '{1, 2'b10, 6'h00, 6'h14, 2'b00, 2'b10, 6'h14, 0, 1, 2'b10, 2'b10, 0};
      tv[20] = '{1, 2'b10, 6'h00, 6'h20, 2'b10, 2'b10, 6'h11, 1, 1, 2'b10, 2'b10, 0};
      tv[21] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 6'h12, 1, 1, 2'b00, 2'b10, 0};
      tv[22] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 6'h13, 1, 1, 2'b00, 2'b00, 0};
      tv[23] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 6'h14, 1, 1, 2'b00, 2'b00, 0};
      tv[24] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b00, 6'h20, 1, 1, 2'b00, 2'b00, 0};
      tv[25] = '{1, 2'b00, 6'h00, 6'h00, 2'b01, 2'b00, 6'h20, 0, 1, 2'b00, 2'b00, 1};
      tv[26] = '{1, 2'b00, 6'h00, 6'h00, 2'b00, 2'b00, 6'h20, 0, 1, 2'b00, 2'b00, 0};
      tv[27] = '{1, 2'b11, 6'h01, 6'h02, 2'b00, 2'b11, 6'h20, 0, 1, 2'b00, 2'b00, 0};
      tv[28] = '{1, 2'b00, 6'h00, 6'h00, 2'b11, 2'b10, 6'h01, 1, 0, 2'b00, 2'b00, 1};
      tv[29] = '{1, 2'b00, 6'h00, 6'h00, 2'b10, 2'b00, 6'h02, 1, 1, 2'b00, 2'b00, 0};
      tv[30] = '{1, 2'b01, 6'h07, 6'h00, 2'b00, 2'b01, 6'h02, 0, 1, 2'b00, 2'b00, 0};
      tv[31] = '{1, 2'b01, 6'h08, 6'h00, 2'b00, 2'b01, 6'h02, 0, 1, 2'b00, 2'b00, 0};
      tv[32] = '{1, 2'b01, 6'h09, 6'h00, 2'b00, 2'b01, 6'h02, 0, 1, 2'b00, 2'b01, 0};
      tv[33] = '{0, 2'b01, 6'h0F, 6'h00, 2'b01, 2'b00, 6'h00, 0, 0, 2'b00, 2'b00, 0};
      tv[34] = '{1, 2'b00, 6'h00, 6'h00, 2'b01, 2'b00, 6'h00, 0, 0, 2'b00, 2'b00, 1};
      tv[35] = '{1, 2'b01, 6'h2A, 6'h00, 2'b01, 2'b01, 6'h00, 0, 0, 2'b00, 2'b00, 1};
      tv[36] = '{1, 2'b00, 6'h00, 6'h00, 2'b01, 2'b00, 6'h2A, 1, 0, 2'b00, 2'b00, 0};

      drive(1'b0, 2'b00, '0, '0, 2'b00);

      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         drive(tv[i].rst_n, tv[i].push, tv[i].d0, tv[i].d1, tv[i].pop);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), tv[i].req, tv[i].dout, tv[i].vld, tv[i].port,
               tv[i].full, tv[i].af, tv[i].err);
      end

      // Fill FIFO0, then drain it on consecutive cycles: no bubbles allowed.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 2'b01, 6'(6'h30 + i), '0, 2'b00);
      end
      @(negedge clk);
      drive(1'b1, 2'b00, '0, '0, 2'b00);
      @(posedge clk);
      #1;
      check("fill_full", 2'b01, 6'h2A, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 2'b00, '0, '0, 2'b01);
         @(posedge clk);
         #1;
         check($sformatf("drain%0d", i), (i == 3) ? 2'b00 : 2'b01, 6'(6'h30 + i),
               1'b1, 1'b0, 2'b00, (i == 0) ? 2'b01 : 2'b00, 1'b0);
      end
      @(negedge clk);
      drive(1'b1, 2'b00, '0, '0, 2'b00);
      @(posedge clk);
      #1;
      check("drain_idle", 2'b00, 6'h33, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
